// File: rtl/count_step_gen.sv
// count_step_gen: synchronises and debounces the step/mode push-buttons and
// produces a single-cycle step_en pulse for the downstream 3-bit counter,
// either once per step press (MANUAL) or every TICK_DIV cycles (AUTO).
//
// state  | meaning
// -------+-------------------------------------------------------------
// MANUAL | step_en follows debounced btn_step presses; prescaler held 0
// AUTO   | step_en pulses every TICK_DIV cycles; btn_step presses ignored
module count_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 100_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_step,
  input  logic btn_mode,
  output logic step_en,
  output logic auto_mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  // Bit 0 carries the step button, bit 1 the mode button.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  mode_t           state_q;
  mode_t           state_n;
  logic [PS_W-1:0] presc_q;
  logic [PS_W-1:0] presc_n;
  logic            step_n;

  // Two-flop synchronisers for the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_mode, btn_step};
      sync2 <= sync1;
    end
  end

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Registered rising-edge detect of the debounced levels; releases are dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      db_d  <= '0;
      press <= '0;
    end else begin
      db_d  <= db;
      press <= db & ~db_d;
    end
  end

  // Mode state, prescaler and step pulse registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= MANUAL;
      presc_q <= '0;
      step_en <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      step_en <= step_n;
    end
  end

  // Next-state logic; a mode press always beats a tick or a step press.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    step_n  = 1'b0;
    case (state_q)
      MANUAL: begin
        presc_n = '0;
        if (press[1]) begin
          state_n = AUTO;
        end else if (press[0]) begin
          step_n = 1'b1;
        end
      end
      AUTO: begin
        if (press[1]) begin
          state_n = MANUAL;
          presc_n = '0;
        end else if (presc_q == PS_LAST) begin
          step_n  = 1'b1;
          presc_n = '0;
        end else begin
          presc_n = presc_q + PS_W'(1);
        end
      end
      default: begin
        state_n = MANUAL;
        presc_n = '0;
      end
    endcase
  end

  assign auto_mode = (state_q == AUTO);

endmodule

// File: doc/count_step_gen.md
# count_step_gen

Step-pulse generator that sits directly upstream of the 3-bit T-flip-flop counter and drives its step/enable input. It synchronises and debounces two push-buttons. It then produces a single-cycle `step_en` pulse, either once per `btn_step` press (MANUAL mode) or periodically from an internal prescaler (AUTO mode). `btn_mode` toggles between the two modes. All logic runs on the single system clock; the counter consumes `step_en` as its advance qualifier.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronised button must differ from its debounced state before the debounced state flips. Must be ≥ 2.
- `TICK_DIV`, default 100_000_000: AUTO-mode period of `step_en` in clk cycles. Must be ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `btn_step`  in  1  raw asynchronous push-button, active-high; manual step request.
- `btn_mode`  in  1  raw asynchronous push-button, active-high; toggles MANUAL/AUTO on each debounced press.
- `step_en`  out  1  registered single-cycle step pulse to the counter.
- `auto_mode`  out  1  registered mode indicator: 0 = MANUAL, 1 = AUTO.

## Operation
- **Reset.** While `rstn`=0 at a rising edge, every register is cleared:
  - both 2-FF synchroniser chains and both debounced states → 0;
  - debounce counters and prescaler → 0;
  - `auto_mode` → 0 (MANUAL);
  - `step_en` → 0.
- **Synchroniser.** Each button passes through its own 2-FF chain, giving `s_step` and `s_mode`.
- **Debounce, per button, independent.**
  - Counter clears whenever the synchronised value equals the debounced state.
  - Otherwise the counter increments by 1.
  - When the counter holds `DEBOUNCE_CYCLES`-1 and the values still differ, the debounced state flips at the next edge and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`; the counter never wraps.
- **Press detection.** A press is a registered rising edge of the debounced state (debounced=1, previous=0). Releases generate nothing.
- **Mode toggle.** A `btn_mode` press inverts `auto_mode`.
- **MANUAL mode.**
  - A `btn_step` press drives `step_en`=1 for exactly one cycle.
  - The prescaler is held at 0.
- **AUTO mode.**
  - The prescaler counts 0..`TICK_DIV`-1 and wraps to 0.
  - `step_en` is registered from (prescaler == `TICK_DIV`-1), giving exactly one pulse every `TICK_DIV` cycles.
  - `btn_step` presses are debounced but ignored.
- **Simultaneous mode press and AUTO tick.** The mode change wins:
  - `step_en` stays 0 that cycle;
  - the prescaler clears;
  - `auto_mode` flips.
- **Simultaneous mode press and manual step press.** No step pulse is issued; the mode flips.
- **Button held across reset release.** The debounced state restarts at 0, so a held button is reported as a new press after the normal debounce latency.

## Timing
- **Press latency.** The button is first sampled high at edge E and stays stable afterwards. The corresponding effect appears after edge E+`DEBOUNCE_CYCLES`+3:
  - `step_en` is high in MANUAL mode for a `btn_step` press;
  - `auto_mode` toggles for a `btn_mode` press.
- The latency breaks down as:
  - 2 cycles of synchroniser;
  - `DEBOUNCE_CYCLES` cycles of debounce;
  - 1 cycle for the registered edge.
- **Glitches.** Any return of the synchronised input to the debounced value restarts the full `DEBOUNCE_CYCLES` window.
- **AUTO entry.** `auto_mode` rises after edge A. The first `step_en` is high after edge A+`TICK_DIV`, then every `TICK_DIV` edges thereafter.
- **AUTO exit.** `auto_mode` falls and `step_en`=0 after the same edge; no trailing pulse follows.
- **Pulse width.** `step_en` is never high for two consecutive cycles.
- **Reset mid-operation.** `rstn`=0 sampled at edge R forces `step_en`=0 and `auto_mode`=0 after R, regardless of in-flight debounce or prescaler state.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `TICK_DIV`=8.
- **Reset:** hold `rstn`=0 for 3 cycles with both buttons toggling → `step_en`=0 and `auto_mode`=0 throughout and on the first cycle after release.
- **Clean press:** `btn_step` first sampled high at edge 10, held 20 cycles, then released → `step_en`=1 only in the cycle after edge 17; no pulse on release; `auto_mode` stays 0.
- **Bounce:** `btn_step` toggles every 2 cycles for 12 cycles, then is held high from edge F → exactly one `step_en` pulse, after edge F+7.
- **AUTO mode:** `btn_mode` press → `auto_mode`=1 after edge A; `step_en` pulses after A+8, A+16, A+24; `btn_step` presses during AUTO add no pulses.
- **Collision:** in AUTO, time the `btn_mode` press so `auto_mode` would fall on the same edge as a tick → no pulse on that cycle, `auto_mode`=0, and no further pulses for 20 cycles.
- **Reset mid-AUTO:** pulse `rstn`=0 for one edge while prescaler=5 → `auto_mode`=0 and `step_en`=0 after that edge; no `step_en` pulse follows without a new button press.
